// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS main-control FSM with stretchable memory accesses,
// bne/addi/j decoding, a sticky illegal-opcode trap and a state debug port.
module mips_multicycle_ctrl #(
  parameter int MEM_LAT    = 1,
  parameter bit WAIT_READY = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic       zero,
  input  logic       memready,
  output logic       memread,
  output logic       memwrite,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic       pcen,
  output logic [1:0] pcsource,
  output logic       memtoreg,
  output logic       regdst,
  output logic       iord,
  output logic       regwrite,
  output logic       irwrite,
  output logic [1:0] aluop,
  output logic       illegal,
  output logic [3:0] state_dbg
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,  S_MEMWR  = 4'd5,  S_RTEX   = 4'd6,  S_RTWB   = 4'd7,
    S_BEQEX  = 4'd8,  S_BNEEX  = 4'd9,  S_ADDIEX = 4'd10, S_ADDIWB = 4'd11,
    S_JEX    = 4'd12, S_TRAP   = 4'd13
  } state_t;

  localparam int            CW   = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [CW-1:0] LAST = CW'(MEM_LAT - 1);

  state_t        r_state, w_next;
  logic [CW-1:0] r_wait_cnt;
  logic          r_illegal;
  logic          w_mem_state, w_done;

  // Memory handshake: memread/memwrite stay high for the whole memory state;
  // the access completes in the first cycle where at least MEM_LAT cycles have
  // elapsed and (when WAIT_READY) memready=1. Earlier memready is ignored.
  assign w_mem_state = (r_state == S_FETCH) || (r_state == S_MEMRD) || (r_state == S_MEMWR);
  assign w_done      = w_mem_state && (r_wait_cnt == LAST) && (memready || !WAIT_READY);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_FETCH;
      r_wait_cnt <= '0;
      r_illegal  <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_mem_state && !w_done) begin
        if (r_wait_cnt != LAST) r_wait_cnt <= r_wait_cnt + 1'b1;
      end else begin
        r_wait_cnt <= '0;
      end
      if (w_next == S_TRAP) r_illegal <= 1'b1;
    end
  end

  always_comb begin
    w_next   = r_state;
    memread  = 1'b0;
    memwrite = 1'b0;
    alusrca  = 1'b0;
    alusrcb  = 2'b00;
    pcen     = 1'b0;
    pcsource = 2'b00;
    memtoreg = 1'b0;
    regdst   = 1'b0;
    iord     = 1'b0;
    regwrite = 1'b0;
    irwrite  = 1'b0;
    aluop    = 2'b00;
    case (r_state)
      S_FETCH: begin
        memread = 1'b1;
        alusrcb = 2'b01;
        irwrite = w_done;
        pcen    = w_done;
        if (w_done) w_next = S_DECODE;
      end
      S_DECODE: begin
        alusrcb = 2'b11;
        case (op)
          6'b100011, 6'b101011: w_next = S_MEMADR;
          6'b000000:            w_next = S_RTEX;
          6'b000100:            w_next = S_BEQEX;
          6'b000101:            w_next = S_BNEEX;
          6'b001000:            w_next = S_ADDIEX;
          6'b000010:            w_next = S_JEX;
          default:              w_next = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        w_next  = (op == 6'b100011) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        memread = 1'b1;
        iord    = 1'b1;
        if (w_done) w_next = S_MEMWB;
      end
      S_MEMWB: begin
        regwrite = 1'b1;
        memtoreg = 1'b1;
        w_next   = S_FETCH;
      end
      S_MEMWR: begin
        memwrite = 1'b1;
        iord     = 1'b1;
        if (w_done) w_next = S_FETCH;
      end
      S_RTEX: begin
        alusrca = 1'b1;
        aluop   = 2'b10;
        w_next  = S_RTWB;
      end
      S_RTWB: begin
        regwrite = 1'b1;
        regdst   = 1'b1;
        w_next   = S_FETCH;
      end
      S_BEQEX, S_BNEEX: begin
        alusrca  = 1'b1;
        aluop    = 2'b01;
        pcsource = 2'b01;
        pcen     = (r_state == S_BEQEX) ? zero : !zero;
        w_next   = S_FETCH;
      end
      S_ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        w_next  = S_ADDIWB;
      end
      S_ADDIWB: begin
        regwrite = 1'b1;
        w_next   = S_FETCH;
      end
      S_JEX: begin
        pcsource = 2'b10;
        pcen     = 1'b1;
        w_next   = S_FETCH;
      end
      S_TRAP:  w_next = S_TRAP;
      default: w_next = S_FETCH;
    endcase

    illegal   = r_illegal;
    state_dbg = r_state;
    // Reset silences every output so an aborted access issues no enables.
    if (reset) begin
      memread   = 1'b0;
      memwrite  = 1'b0;
      alusrca   = 1'b0;
      alusrcb   = 2'b00;
      pcen      = 1'b0;
      pcsource  = 2'b00;
      memtoreg  = 1'b0;
      regdst    = 1'b0;
      iord      = 1'b0;
      regwrite  = 1'b0;
      irwrite   = 1'b0;
      aluop     = 2'b00;
      illegal   = 1'b0;
      state_dbg = 4'd0;
    end
  end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Bench for mips_multicycle_ctrl: two instances (MEM_LAT=1 and MEM_LAT=3 with
// memready) checked every cycle against an instruction-path model.
module tb_mips_multicycle_ctrl;

  typedef struct packed {
    logic [3:0] st;
    logic       mr, mw, asa;
    logic [1:0] asb;
    logic       pcen;
    logic [1:0] pcs;
    logic       m2r, rdst, iord, rw, irw;
    logic [1:0] aop;
    logic       ill;
  } ctl_t;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst[2];
  logic [5:0] op[2];
  logic       zero[2], rdy[2];
  logic       mr[2], mw[2], asa[2], pcen[2], m2r[2], rdst[2], iord[2], rw[2], irw[2], ill[2];
  logic [1:0] asb[2], pcs[2], aop[2];
  logic [3:0] st[2];

  mips_multicycle_ctrl #(.MEM_LAT(1), .WAIT_READY(1'b0)) u_dut0 (
    .clk(clk), .reset(rst[0]), .op(op[0]), .zero(zero[0]), .memready(rdy[0]),
    .memread(mr[0]), .memwrite(mw[0]), .alusrca(asa[0]), .alusrcb(asb[0]),
    .pcen(pcen[0]), .pcsource(pcs[0]), .memtoreg(m2r[0]), .regdst(rdst[0]),
    .iord(iord[0]), .regwrite(rw[0]), .irwrite(irw[0]), .aluop(aop[0]),
    .illegal(ill[0]), .state_dbg(st[0])
  );

  mips_multicycle_ctrl #(.MEM_LAT(3), .WAIT_READY(1'b1)) u_dut1 (
    .clk(clk), .reset(rst[1]), .op(op[1]), .zero(zero[1]), .memready(rdy[1]),
    .memread(mr[1]), .memwrite(mw[1]), .alusrca(asa[1]), .alusrcb(asb[1]),
    .pcen(pcen[1]), .pcsource(pcs[1]), .memtoreg(m2r[1]), .regdst(rdst[1]),
    .iord(iord[1]), .regwrite(rw[1]), .irwrite(irw[1]), .aluop(aop[1]),
    .illegal(ill[1]), .state_dbg(st[1])
  );

  int checks = 0;
  int errors = 0;

  // ---------------- behavioural model ----------------
  int m_st[2]   = '{0, 0};
  int m_acc[2]  = '{0, 0};
  bit m_ill[2]  = '{0, 0};
  int m_path[2][4];
  int m_len[2]  = '{0, 0};
  int m_idx[2]  = '{0, 0};

  function automatic int ml(int d);
    return (d == 0) ? 1 : 3;
  endfunction

  function automatic bit wr(int d);
    return (d == 0) ? 1'b0 : 1'b1;
  endfunction

  // Control word each step must show (dynamic pcen/irwrite/illegal added later)
  function automatic ctl_t base(int s);
    ctl_t b;
    b = '0;
    b.st = 4'(s);
    case (s)
      0:       begin b.mr = 1; b.asb = 2'b01; end
      1:       b.asb = 2'b11;
      2:       begin b.asa = 1; b.asb = 2'b10; end
      3:       begin b.mr = 1; b.iord = 1; end
      4:       begin b.rw = 1; b.m2r = 1; end
      5:       begin b.mw = 1; b.iord = 1; end
      6:       begin b.asa = 1; b.aop = 2'b10; end
      7:       begin b.rw = 1; b.rdst = 1; end
      8, 9:    begin b.asa = 1; b.aop = 2'b01; b.pcs = 2'b01; end
      10:      begin b.asa = 1; b.asb = 2'b10; end
      11:      b.rw = 1;
      12:      b.pcs = 2'b10;
      default: ;
    endcase
    return b;
  endfunction

  function automatic bit mem_done(int d);
    bit is_mem;
    is_mem = (m_st[d] == 0) || (m_st[d] == 3) || (m_st[d] == 5);
    return is_mem && (m_acc[d] == ml(d) - 1) && (rdy[d] || !wr(d));
  endfunction

  task automatic set_path(input int d, input logic [5:0] o);
    m_len[d] = 1;
    case (o)
      6'b100011: begin m_path[d][0] = 2;  m_path[d][1] = 3; m_path[d][2] = 4; m_len[d] = 3; end
      6'b101011: begin m_path[d][0] = 2;  m_path[d][1] = 5; m_len[d] = 2; end
      6'b000000: begin m_path[d][0] = 6;  m_path[d][1] = 7; m_len[d] = 2; end
      6'b000100: m_path[d][0] = 8;
      6'b000101: m_path[d][0] = 9;
      6'b001000: begin m_path[d][0] = 10; m_path[d][1] = 11; m_len[d] = 2; end
      6'b000010: m_path[d][0] = 12;
      default:   m_path[d][0] = 13;
    endcase
  endtask

  function automatic ctl_t expv(int d);
    ctl_t e;
    bit   dn;
    e  = base(m_st[d]);
    dn = mem_done(d);
    if (m_st[d] == 0) begin e.pcen = dn; e.irw = dn; end
    if (m_st[d] == 8)  e.pcen = zero[d];
    if (m_st[d] == 9)  e.pcen = !zero[d];
    if (m_st[d] == 12) e.pcen = 1'b1;
    e.ill = m_ill[d];
    if (rst[d]) e = '0;
    return e;
  endfunction

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rst[d]) begin
        m_st[d] = 0; m_acc[d] = 0; m_ill[d] = 0;
      end else if (m_st[d] == 13) begin
        m_st[d] = 13;
      end else if (m_st[d] == 1) begin
        set_path(d, op[d]);
        m_st[d]  = m_path[d][0];
        m_idx[d] = 1;
      end else if (((m_st[d] == 0) || (m_st[d] == 3) || (m_st[d] == 5)) && !mem_done(d)) begin
        if (m_acc[d] < ml(d) - 1) m_acc[d]++;
      end else begin
        m_acc[d] = 0;
        if (m_st[d] == 0) m_st[d] = 1;
        else if (m_idx[d] < m_len[d]) begin
          m_st[d] = m_path[d][m_idx[d]];
          m_idx[d]++;
        end else m_st[d] = 0;
      end
      if (m_st[d] == 13) m_ill[d] = 1'b1;
    end
  end

  // ---------------- per-cycle compare + trace capture ----------------
  ctl_t tr0[$], tr1[$];
  bit   rec[2] = '{0, 0};

  function automatic ctl_t act(int d);
    return {st[d], mr[d], mw[d], asa[d], asb[d], pcen[d], pcs[d], m2r[d],
            rdst[d], iord[d], rw[d], irw[d], aop[d], ill[d]};
  endfunction

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      ctl_t a, e;
      a = act(d);
      e = expv(d);
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL cycle_dut%0d t=%0t got=%h exp=%h", d, $time, a, e);
      end
    end
    if (rec[0]) tr0.push_back(act(0));
    if (rec[1]) tr1.push_back(act(1));
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      rdy[0] = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic do_reset(input int d);
    rst[d] = 1'b1;
    tick(1);
    rst[d] = 1'b0;
  endtask

  task automatic start_rec(input int d);
    if (d == 0) tr0.delete(); else tr1.delete();
    rec[d] = 1'b1;
  endtask

  function automatic ctl_t trv(int d, int i);
    if (d == 0) return (i < tr0.size()) ? tr0[i] : '1;
    return (i < tr1.size()) ? tr1[i] : '1;
  endfunction

  task automatic pin(input string name, input int a, input int e);
    checks++;
    if (a != e) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", name, a, e);
    end
  endtask

  // ---------------- scoreboard for pinned state traces ----------------
  logic [3:0] exp_q[$];

  task automatic chk_states(input int d, input string name);
    ctl_t t;
    int   n;
    n = exp_q.size();
    for (int i = 0; i < n; i++) begin
      t = trv(d, i);
      pin(name, int'(t.st), int'(exp_q[i]));
    end
    exp_q.delete();
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    ctl_t t;
    int   cnt_a, cnt_b, idx;
    rst  = '{1'b1, 1'b1};
    op   = '{6'd0, 6'd0};
    zero = '{1'b0, 1'b0};
    rdy  = '{1'b0, 1'b0};
    tick(2);

    // lw then R-type, MEM_LAT=1
    do_reset(0);
    start_rec(0);
    op[0] = 6'b100011; tick(5);
    op[0] = 6'b000000; tick(5);
    rec[0] = 0;
    exp_q = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd0, 4'd1, 4'd6, 4'd7, 4'd0};
    chk_states(0, "lw_r_state");
    cnt_a = 0;
    for (int i = 0; i < 10; i++) begin t = trv(0, i); cnt_a += int'(t.rw); end
    pin("lw_r_regwrite_count", cnt_a, 2);
    t = trv(0, 4); pin("memwb_regwrite", int'(t.rw), 1);
    t = trv(0, 8); pin("rtwb_regwrite", int'(t.rw), 1);

    // stretched fetch: MEM_LAT=3, memready low for 5 cycles
    do_reset(1);
    op[1] = 6'b000000; rdy[1] = 1'b0;
    start_rec(1);
    tick(5); rdy[1] = 1'b1; tick(1); rdy[1] = 1'b0; tick(2);
    rec[1] = 0;
    exp_q = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd1, 4'd6};
    chk_states(1, "stall_state");
    cnt_a = 0; cnt_b = 0; idx = -1;
    for (int i = 0; i < 8; i++) begin
      t = trv(1, i);
      cnt_a += int'(t.mr);
      cnt_b += int'(t.irw);
      if (t.irw && t.pcen) idx = i;
    end
    pin("stall_memread_cycles", cnt_a, 6);
    pin("stall_irwrite_pulses", cnt_b, 1);
    pin("stall_irwrite_cycle", idx, 5);

    // memready held high early does not shorten the 3-cycle access
    rdy[1] = 1'b1;
    start_rec(1);
    tick(5);
    rec[1] = 0;
    exp_q = '{4'd7, 4'd0, 4'd0, 4'd0, 4'd1};
    chk_states(1, "early_ready_state");

    // beq zero=1, bne zero=1, bne zero=0
    do_reset(0);
    start_rec(0);
    op[0] = 6'b000100; zero[0] = 1'b1; tick(3);
    op[0] = 6'b000101; zero[0] = 1'b1; tick(3);
    op[0] = 6'b000101; zero[0] = 1'b0; tick(4);
    rec[0] = 0;
    exp_q = '{4'd0, 4'd1, 4'd8, 4'd0, 4'd1, 4'd9, 4'd0, 4'd1, 4'd9, 4'd0};
    chk_states(0, "branch_state");
    t = trv(0, 2); pin("beq_taken_pcen", int'(t.pcen), 1);
    t = trv(0, 5); pin("bne_zero1_pcen", int'(t.pcen), 0);
    t = trv(0, 8); pin("bne_zero0_pcen", int'(t.pcen), 1);
    t = trv(0, 8); pin("bne_pcsource", int'(t.pcs), 1);

    // illegal opcode trap
    do_reset(0);
    start_rec(0);
    op[0] = 6'b111111; tick(12);
    rec[0] = 0;
    cnt_a = 0; cnt_b = 0;
    for (int i = 2; i < 12; i++) begin
      t = trv(0, i);
      cnt_a += int'(t.ill && t.st == 4'd13);
      cnt_b += int'(t.mr | t.mw | t.pcen | t.rw | t.irw);
    end
    pin("trap_illegal_cycles", cnt_a, 10);
    pin("trap_enable_cycles", cnt_b, 0);
    op[0] = 6'b000000;
    do_reset(0);
    start_rec(0);
    tick(1);
    rec[0] = 0;
    t = trv(0, 0);
    pin("trap_reset_illegal", int'(t.ill), 0);
    pin("trap_reset_state", int'(t.st), 0);

    // reset during a MEM_LAT=3 store
    do_reset(1);
    op[1] = 6'b101011; rdy[1] = 1'b1;
    tick(5);
    start_rec(1);
    tick(1);
    rst[1] = 1'b1; tick(1); rst[1] = 1'b0;
    tick(4);
    rec[1] = 0;
    exp_q = '{4'd5, 4'd0, 4'd0, 4'd0, 4'd0, 4'd1};
    chk_states(1, "memwr_reset_state");
    t = trv(1, 0); pin("memwr_memwrite", int'(t.mw), 1);
    t = trv(1, 1); pin("memwr_reset_memwrite", int'(t.mw), 0);
    t = trv(1, 2); pin("after_reset_memwrite", int'(t.mw), 0);

    // j then addi
    do_reset(0);
    start_rec(0);
    op[0] = 6'b000010; tick(3);
    op[0] = 6'b001000; tick(5);
    rec[0] = 0;
    exp_q = '{4'd0, 4'd1, 4'd12, 4'd0, 4'd1, 4'd10, 4'd11, 4'd0};
    chk_states(0, "j_addi_state");
    t = trv(0, 2); pin("j_pcsource", int'(t.pcs), 2);
    t = trv(0, 2); pin("j_pcen", int'(t.pcen), 1);
    t = trv(0, 5); pin("addiex_alusrcb", int'(t.asb), 2);
    t = trv(0, 6);
    pin("addiwb_regwrite", int'(t.rw), 1);
    pin("addiwb_regdst", int'(t.rdst), 0);
    pin("addiwb_memtoreg", int'(t.m2r), 0);

    rst = '{1'b1, 1'b1};
    tick(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
